// File: rtl/video_capture_wshb.sv
// video_capture_wshb: samples a video pixel stream and writes each active pixel as one
// 32-bit word into a framebuffer through a classic Wishbone write master.
//
// state   | meaning
// WAIT_VS | after reset, pixels discarded until the first frame sync
// CAPTURE | active pixels pushed into the FIFO
// DROP    | FIFO overflowed, pixels discarded until the next frame sync
module video_capture_wshb #(
    parameter int          HDISP       = 800,
    parameter int          VDISP       = 480,
    parameter logic [31:0] BASE_ADR    = 32'h0000_0000,
    parameter int          DEPTH_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vid_hs,
    input  logic        vid_vs,
    input  logic        vid_blank,
    input  logic [23:0] vid_rgb,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [3:0]  wb_sel,
    output logic [2:0]  wb_cti,
    output logic [1:0]  wb_bte,
    output logic [31:0] wb_adr,
    output logic [31:0] wb_dat_ms,
    input  logic        wb_ack,
    output logic        overflow,
    output logic        frame_done
);

    localparam int NPIX  = HDISP * VDISP;
    localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NPIX - 1);
    localparam int DEPTH = 1 << DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0] CNT_FULL = (DEPTH_WIDTH + 1)'(DEPTH);
    localparam logic [DEPTH_WIDTH:0] CNT_ONE  = (DEPTH_WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        CAPTURE = 2'd1,
        DROP    = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic        hs_q, vs_q, vs_q2, blank_q;
    logic [23:0] rgb_q;
    logic        vs_start;
    logic        unused_hs;

    logic        sof_pend;
    logic        push_req, drop_px, pop;

    logic [24:0]            mem [DEPTH];
    logic [DEPTH_WIDTH-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [DEPTH_WIDTH:0]   count;
    logic                   fifo_full, fifo_empty, more_queued;
    logic [24:0]            head, head_nxt;

    logic [IDX_W-1:0] idx, idx_adv;
    logic [31:0]      adr_adv;
    logic             last_word;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            vs_q2   <= 1'b1;
            blank_q <= 1'b0;
            rgb_q   <= '0;
        end else begin
            hs_q    <= vid_hs;
            vs_q    <= vid_vs;
            vs_q2   <= vs_q;
            blank_q <= vid_blank;
            rgb_q   <= vid_rgb;
        end
    end

    assign vs_start  = vs_q2 & ~vs_q;
    assign unused_hs = hs_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= WAIT_VS;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_VS: if (vs_start) state_nxt = CAPTURE;
            CAPTURE: begin
                if (vs_start)                    state_nxt = CAPTURE;
                else if (blank_q && fifo_full)   state_nxt = DROP;
            end
            DROP:    if (vs_start) state_nxt = CAPTURE;
            default: state_nxt = WAIT_VS;
        endcase
    end

    // A pixel arriving together with the frame sync belongs to neither frame and is discarded.
    always_comb begin
        push_req = 1'b0;
        drop_px  = 1'b0;
        if (state == CAPTURE && !vs_start && blank_q) begin
            if (fifo_full) drop_px  = 1'b1;
            else           push_req = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sof_pend <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (vs_start)      sof_pend <= 1'b1;
            else if (push_req) sof_pend <= 1'b0;
            if (drop_px)       overflow <= 1'b1;
        end
    end

    // The word on the bus stays in the FIFO until acked, so full counts it as well.
    assign fifo_full   = (count == CNT_FULL);
    assign fifo_empty  = (count == '0);
    assign more_queued = (count > CNT_ONE);
    assign pop         = wb_cyc & wb_ack;
    assign rd_ptr_nxt  = rd_ptr + DEPTH_WIDTH'(1);
    assign head        = mem[rd_ptr];
    assign head_nxt    = mem[rd_ptr_nxt];

    always_ff @(posedge clk) begin
        if (push_req) mem[wr_ptr] <= {sof_pend, rgb_q};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_req) wr_ptr <= wr_ptr + DEPTH_WIDTH'(1);
            if (pop)      rd_ptr <= rd_ptr_nxt;
            count <= count + {{DEPTH_WIDTH{1'b0}}, push_req} - {{DEPTH_WIDTH{1'b0}}, pop};
        end
    end

    assign last_word = (idx == IDX_LAST);
    assign adr_adv   = last_word ? BASE_ADR : wb_adr + 32'd4;
    assign idx_adv   = last_word ? '0 : idx + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_cyc     <= 1'b0;
            wb_adr     <= BASE_ADR;
            wb_dat_ms  <= '0;
            idx        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (wb_cyc) begin
                if (wb_ack) begin
                    frame_done <= last_word;
                    if (more_queued) begin
                        wb_dat_ms <= {8'h00, head_nxt[23:0]};
                        wb_adr    <= head_nxt[24] ? BASE_ADR : adr_adv;
                        idx       <= head_nxt[24] ? '0 : idx_adv;
                    end else begin
                        wb_cyc <= 1'b0;
                        wb_adr <= adr_adv;
                        idx    <= idx_adv;
                    end
                end
            end else if (!fifo_empty) begin
                wb_cyc    <= 1'b1;
                wb_dat_ms <= {8'h00, head[23:0]};
                if (head[24]) begin
                    wb_adr <= BASE_ADR;
                    idx    <= '0;
                end
            end
        end
    end

    assign wb_stb = wb_cyc;
    assign wb_we  = 1'b1;
    assign wb_sel = 4'b1111;
    assign wb_cti = 3'b000;
    assign wb_bte = 2'b00;

endmodule

// File: tb/tb_video_capture_wshb.sv
// Directed bench for video_capture_wshb on a 4x2 frame with a 256-entry FIFO.
`timescale 1ns/1ps
module tb_video_capture_wshb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vid_hs, vid_vs, vid_blank;
    logic [23:0] vid_rgb;
    logic        wb_cyc, wb_stb, wb_we, wb_ack;
    logic [3:0]  wb_sel;
    logic [2:0]  wb_cti;
    logic [1:0]  wb_bte;
    logic [31:0] wb_adr, wb_dat_ms;
    logic        overflow, frame_done;

    always #5 clk = ~clk;

    video_capture_wshb #(
        .HDISP(4), .VDISP(2), .BASE_ADR(32'h0), .DEPTH_WIDTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_blank(vid_blank), .vid_rgb(vid_rgb),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
        .wb_cti(wb_cti), .wb_bte(wb_bte), .wb_adr(wb_adr), .wb_dat_ms(wb_dat_ms),
        .wb_ack(wb_ack), .overflow(overflow), .frame_done(frame_done)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] adr_log[$];
    logic [31:0] dat_log[$];
    int fd_count = 0;
    int fd_pos = -1;
    int stab_err = 0;
    int ack_mode = 0;

    // Bus monitor: logs acked writes, frame_done pulses and changes during wait states.
    initial begin
        logic        p_wait;
        logic [31:0] p_adr, p_dat;
        p_wait = 1'b0;
        p_adr  = '0;
        p_dat  = '0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                p_wait = 1'b0;
            end else begin
                if (p_wait && (!wb_cyc || !wb_stb || wb_adr !== p_adr || wb_dat_ms !== p_dat))
                    stab_err++;
                if (frame_done) begin
                    fd_count++;
                    fd_pos = adr_log.size();
                end
                if (wb_cyc && wb_ack) begin
                    adr_log.push_back(wb_adr);
                    dat_log.push_back(wb_dat_ms);
                end
                p_wait = wb_cyc && !wb_ack;
                p_adr  = wb_adr;
                p_dat  = wb_dat_ms;
            end
        end
    end

    // Slave: mode 0 never acks, 1 acks every cycle, 2 acks after 0..5 random wait states.
    initial begin
        int wcnt;
        wcnt   = 0;
        wb_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (ack_mode == 1) begin
                wb_ack = 1'b1;
            end else if (ack_mode == 2 && wb_cyc) begin
                if (wcnt == 0) begin
                    wb_ack = 1'b1;
                    wcnt   = $urandom_range(0, 5);
                end else begin
                    wb_ack = 1'b0;
                    wcnt--;
                end
            end else begin
                wb_ack = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_logs();
        adr_log.delete();
        dat_log.delete();
        fd_count = 0;
        fd_pos   = -1;
        stab_err = 0;
    endtask

    task automatic pix(input logic [23:0] v);
        vid_blank = 1'b1;
        vid_rgb   = v;
        @(negedge clk);
    endtask

    task automatic vs_pulse();
        vid_blank = 1'b0;
        vid_vs    = 1'b0;
        repeat (2) @(negedge clk);
        vid_vs = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_log(input int n, input int bound);
        for (int i = 0; i < bound && adr_log.size() < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vid_hs = 1'b1; vid_vs = 1'b1; vid_blank = 1'b0; vid_rgb = '0;
        ack_mode = 0;
        repeat (3) @(negedge clk);
        vectors++; if (wb_cyc !== 1'b0 || wb_stb !== 1'b0) begin miscompares++;
            $display("FAIL reset_cyc: got cyc=%b stb=%b expected 0 0", wb_cyc, wb_stb); end
        vectors++; if (wb_adr !== 32'h0) begin miscompares++;
            $display("FAIL reset_adr: got %h expected 00000000", wb_adr); end
        vectors++; if (wb_dat_ms !== 32'h0) begin miscompares++;
            $display("FAIL reset_dat: got %h expected 00000000", wb_dat_ms); end
        vectors++; if (overflow !== 1'b0 || frame_done !== 1'b0) begin miscompares++;
            $display("FAIL reset_flags: got ovf=%b fd=%b expected 0 0", overflow, frame_done); end
        vectors++; if ({wb_we, wb_sel, wb_cti, wb_bte} !== {1'b1, 4'hF, 3'd0, 2'd0}) begin
            miscompares++;
            $display("FAIL const_outputs: got we=%b sel=%h cti=%h bte=%h expected 1 f 0 0",
                     wb_we, wb_sel, wb_cti, wb_bte); end
        rst_n = 1'b1;
        @(negedge clk);
        clear_logs();
    endtask

    task automatic test_pre_vs();
        ack_mode = 1;
        for (int i = 0; i < 5; i++) pix(24'hF0 + 24'(i));
        vid_blank = 1'b0;
        repeat (10) @(negedge clk);
        vectors++; if (adr_log.size() != 0 || wb_cyc !== 1'b0) begin miscompares++;
            $display("FAIL pre_vs_quiet: got %0d writes cyc=%b expected 0 writes cyc=0",
                     adr_log.size(), wb_cyc); end
    endtask

    task automatic test_basic_frame();
        clear_logs();
        ack_mode = 1;
        vs_pulse();
        vid_blank = 1'b1;
        vid_rgb = 24'h1; @(negedge clk);
        vid_rgb = 24'h2; @(negedge clk);
        vid_rgb = 24'h3; @(negedge clk);
        vid_rgb = 24'h4; @(negedge clk);
        vectors++; if (wb_cyc !== 1'b1) begin miscompares++;
            $display("FAIL latency: got cyc=%b 3 edges after first pixel expected 1", wb_cyc); end
        for (int i = 5; i <= 8; i++) begin vid_rgb = 24'(i); @(negedge clk); end
        vid_blank = 1'b0;
        wait_log(8, 50);
        repeat (3) @(negedge clk);
        vectors++; if (adr_log.size() != 8) begin miscompares++;
            $display("FAIL frame_count: got %0d writes expected 8", adr_log.size()); end
        for (int i = 0; i < 8 && i < adr_log.size(); i++) begin
            vectors++;
            if (adr_log[i] !== 32'(4 * i) || dat_log[i] !== 32'(i + 1)) begin miscompares++;
                $display("FAIL frame_word%0d: got adr=%h dat=%h expected adr=%h dat=%h",
                         i, adr_log[i], dat_log[i], 32'(4 * i), 32'(i + 1)); end
        end
        vectors++; if (fd_count != 1 || fd_pos != 8) begin miscompares++;
            $display("FAIL frame_done: got %0d pulses after write %0d expected 1 after 8",
                     fd_count, fd_pos); end
        vectors++; if (overflow !== 1'b0) begin miscompares++;
            $display("FAIL frame_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_vs_restart();
        logic [31:0] exp_adr [11];
        logic [31:0] exp_dat [11];
        clear_logs();
        ack_mode = 1;
        for (int i = 0; i < 3; i++) begin
            exp_adr[i] = 32'(4 * i); exp_dat[i] = 32'h0000A1 + 32'(i);
        end
        for (int i = 0; i < 8; i++) begin
            exp_adr[3 + i] = 32'(4 * i); exp_dat[3 + i] = 32'h0000B0 + 32'(i);
        end
        vs_pulse();
        for (int i = 0; i < 3; i++) pix(24'hA1 + 24'(i));
        vs_pulse();
        for (int i = 0; i < 8; i++) pix(24'hB0 + 24'(i));
        vid_blank = 1'b0;
        wait_log(11, 60);
        repeat (3) @(negedge clk);
        vectors++; if (adr_log.size() != 11) begin miscompares++;
            $display("FAIL restart_count: got %0d writes expected 11", adr_log.size()); end
        for (int i = 0; i < 11 && i < adr_log.size(); i++) begin
            vectors++;
            if (adr_log[i] !== exp_adr[i] || dat_log[i] !== exp_dat[i]) begin miscompares++;
                $display("FAIL restart_word%0d: got adr=%h dat=%h expected adr=%h dat=%h",
                         i, adr_log[i], dat_log[i], exp_adr[i], exp_dat[i]); end
        end
        vectors++; if (fd_count != 1 || fd_pos != 11) begin miscompares++;
            $display("FAIL restart_frame_done: got %0d pulses after write %0d expected 1 after 11",
                     fd_count, fd_pos); end
    endtask

    task automatic test_wait_states();
        clear_logs();
        ack_mode = 2;
        vs_pulse();
        for (int i = 0; i < 8; i++) pix(24'h10 + 24'(i));
        vid_blank = 1'b0;
        wait_log(8, 200);
        repeat (3) @(negedge clk);
        vectors++; if (adr_log.size() != 8) begin miscompares++;
            $display("FAIL wait_count: got %0d writes expected 8", adr_log.size()); end
        for (int i = 0; i < 8 && i < adr_log.size(); i++) begin
            vectors++;
            if (adr_log[i] !== 32'(4 * i) || dat_log[i] !== 32'h10 + 32'(i)) begin miscompares++;
                $display("FAIL wait_word%0d: got adr=%h dat=%h expected adr=%h dat=%h",
                         i, adr_log[i], dat_log[i], 32'(4 * i), 32'h10 + 32'(i)); end
        end
        vectors++; if (stab_err != 0) begin miscompares++;
            $display("FAIL wait_stable: got %0d bus changes during waits expected 0", stab_err); end
        ack_mode = 0;
    endtask

    task automatic test_overflow();
        int bad;
        clear_logs();
        ack_mode = 0;
        vs_pulse();
        for (int i = 1; i <= 256; i++) pix(24'(i));
        vid_blank = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (overflow !== 1'b0) begin miscompares++;
            $display("FAIL ovf_256: got %b after 256 pixels expected 0", overflow); end
        vectors++; if (wb_cyc !== 1'b1 || wb_adr !== 32'h0 || wb_dat_ms !== 32'h1) begin
            miscompares++;
            $display("FAIL ovf_hold: got cyc=%b adr=%h dat=%h expected 1 00000000 00000001",
                     wb_cyc, wb_adr, wb_dat_ms); end
        pix(24'd257);
        vid_blank = 1'b0;
        @(negedge clk);
        vectors++; if (overflow !== 1'b1) begin miscompares++;
            $display("FAIL ovf_257: got %b after 257 pixels expected 1", overflow); end
        for (int i = 258; i <= 300; i++) pix(24'(i));
        vid_blank = 1'b0;
        ack_mode = 1;
        wait_log(256, 400);
        repeat (5) @(negedge clk);
        vectors++; if (adr_log.size() != 256) begin miscompares++;
            $display("FAIL ovf_drain_count: got %0d writes expected 256", adr_log.size()); end
        bad = -1;
        for (int i = 0; i < 256 && i < adr_log.size(); i++)
            if (bad < 0 && (adr_log[i] !== 32'(4 * (i % 8)) || dat_log[i] !== 32'(i + 1))) bad = i;
        vectors++; if (bad >= 0) begin miscompares++;
            $display("FAIL ovf_drain_word%0d: got adr=%h dat=%h expected adr=%h dat=%h", bad,
                     adr_log[bad], dat_log[bad], 32'(4 * (bad % 8)), 32'(bad + 1)); end
        vs_pulse();
        for (int i = 0; i < 8; i++) pix(24'h200 + 24'(i));
        vid_blank = 1'b0;
        wait_log(264, 60);
        repeat (3) @(negedge clk);
        vectors++; if (adr_log.size() != 264) begin miscompares++;
            $display("FAIL ovf_next_count: got %0d writes expected 264", adr_log.size()); end
        for (int i = 0; i < 8 && 256 + i < adr_log.size(); i++) begin
            vectors++;
            if (adr_log[256 + i] !== 32'(4 * i) || dat_log[256 + i] !== 32'h200 + 32'(i)) begin
                miscompares++;
                $display("FAIL ovf_next_word%0d: got adr=%h dat=%h expected adr=%h dat=%h", i,
                         adr_log[256 + i], dat_log[256 + i], 32'(4 * i), 32'h200 + 32'(i)); end
        end
        vectors++; if (overflow !== 1'b1) begin miscompares++;
            $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        ack_mode = 0;
        vs_pulse();
        pix(24'hAA);
        pix(24'hBB);
        vid_blank = 1'b0;
        for (int i = 0; i < 20 && !wb_cyc; i++) @(negedge clk);
        vectors++; if (wb_cyc !== 1'b1) begin miscompares++;
            $display("FAIL rstmid_cycle: got cyc=%b before reset expected 1", wb_cyc); end
        rst_n = 1'b0;
        @(negedge clk);
        vectors++; if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || wb_adr !== 32'h0) begin
            miscompares++;
            $display("FAIL rstmid_bus: got cyc=%b stb=%b adr=%h expected 0 0 00000000",
                     wb_cyc, wb_stb, wb_adr); end
        vectors++; if (overflow !== 1'b0 || wb_dat_ms !== 32'h0) begin miscompares++;
            $display("FAIL rstmid_clear: got ovf=%b dat=%h expected 0 00000000",
                     overflow, wb_dat_ms); end
        rst_n = 1'b1;
        clear_logs();
        ack_mode = 1;
        for (int i = 0; i < 3; i++) pix(24'hCC + 24'(i));
        vid_blank = 1'b0;
        repeat (10) @(negedge clk);
        vectors++; if (adr_log.size() != 0 || wb_cyc !== 1'b0) begin miscompares++;
            $display("FAIL rstmid_idle: got %0d writes cyc=%b expected 0 writes cyc=0",
                     adr_log.size(), wb_cyc); end
        vs_pulse();
        pix(24'hDD);
        vid_blank = 1'b0;
        wait_log(1, 20);
        repeat (3) @(negedge clk);
        vectors++; if (adr_log.size() != 1) begin miscompares++;
            $display("FAIL rstmid_after_count: got %0d writes expected 1", adr_log.size()); end
        else begin
            vectors++; if (adr_log[0] !== 32'h0 || dat_log[0] !== 32'hDD) begin miscompares++;
                $display("FAIL rstmid_after_word: got adr=%h dat=%h expected 00000000 000000dd",
                         adr_log[0], dat_log[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_pre_vs();
        test_basic_frame();
        test_vs_restart();
        test_wait_states();
        test_overflow();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
